// File: rtl/rand_mem_pkg.sv
// rand_mem_pkg: shared widths, FSM state type and output packing helper for the read-update stage
package rand_mem_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {IDLE, READ, OUT} state_e;
  function automatic logic [ADDR_W+DATA_W:0] pack_out(input logic flag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    return {flag, addr, data};
  endfunction
endpackage

// File: rtl/rand_mem_cmp_unit.sv
// rand_mem_cmp_unit: candidate vs read word select (ports cand, rdata -> flag, new_data); MIN_UPDATE_EN keeps the smaller word, otherwise always overwrite
module rand_mem_cmp_unit
  import rand_mem_pkg::*;
#(
  parameter int data_width = DATA_W
) (
  input  logic [data_width-1:0] cand,
  input  logic [data_width-1:0] rdata,
  output logic                  flag,
  output logic [data_width-1:0] new_data
);
`ifdef MIN_UPDATE_EN
  assign flag = cand < rdata;
  assign new_data = flag ? cand : rdata;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;
  assign flag = 1'b1;
  assign new_data = cand;
`endif
endmodule

// File: rtl/rand_mem_read_update_module.sv
// rand_mem_read_update_module: one-in-flight read/compare stage (data_i/valid_i/ready_o in, mem_read/mem_addr/mem_rdata/mem_resp to memory, data_o/valid_o/ready_i out, upd_cnt); MIN_UPDATE_EN selects min-update in rand_mem_cmp_unit
module rand_mem_read_update_module
  import rand_mem_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  parameter int data_width = DATA_W,
  parameter int input_width = addr_width + data_width,
  parameter int output_width = 1 + addr_width + data_width,
  parameter int cnt_width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [input_width-1:0]  data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    mem_read,
  output logic [addr_width-1:0]   mem_addr,
  input  logic [data_width-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic [output_width-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [cnt_width-1:0]    upd_cnt
);
  state_e state, state_n;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] cand_q;
  logic flag;
  logic [data_width-1:0] new_data;
  rand_mem_cmp_unit #(.data_width(data_width)) u_cmp (
    .cand(cand_q),
    .rdata(mem_rdata),
    .flag(flag),
    .new_data(new_data)
  );
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && valid_i) ? READ :
              (state == READ && mem_resp) ? OUT :
              (state == OUT && ready_i) ? IDLE : state;
  end
  assign ready_o = state == IDLE;
  assign mem_read = state == READ;
  assign valid_o = state == OUT;
  assign mem_addr = addr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      cand_q <= '0;
      data_o <= '0;
      upd_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && valid_i) {addr_q, cand_q} <= data_i;
      if (state == READ && mem_resp) data_o <= pack_out(flag, addr_q, new_data);
      if (state == OUT && ready_i && data_o[output_width-1]) upd_cnt <= upd_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rand_mem_read_update_module.sv
// tb_rand_mem_read_update_module: directed self-checking bench for the read-update stage in either MIN_UPDATE_EN build
module tb_rand_mem_read_update_module;
  logic clk = 0;
  logic rst = 0;
  logic [127:0] data_i = '0;
  logic valid_i = 0;
  logic ready_o;
  logic mem_read;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata = '0;
  logic mem_resp = 0;
  logic [128:0] data_o;
  logic valid_o;
  logic ready_i = 0;
  logic [31:0] upd_cnt;
  int checks = 0;
  int fails = 0;
  logic [31:0] exp_cnt = 0;
  logic [128:0] exp_d;
  logic [128:0] held;
  always #5 clk = ~clk;
  rand_mem_read_update_module dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .upd_cnt(upd_cnt)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [63:0] a, input logic [63:0] c);
    valid_i = 1;
    data_i = {a, c};
    step;
    valid_i = 0;
  endtask
  task automatic respond(input logic [63:0] d);
    mem_rdata = d;
    mem_resp = 1;
    step;
    mem_resp = 0;
  endtask
  task automatic accept;
    ready_i = 1;
    step;
    ready_i = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    step;
    step;
    rst = 0;
    checks++; if (ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready_o); end
    checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (mem_read !== 1'b0) begin fails++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    checks++; if (upd_cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", upd_cnt); end
    checks++; if (data_o !== 129'd0) begin fails++; $display("FAIL reset_data got %h want 0", data_o); end
  endtask
  task automatic test_update;
    issue(64'h10, 64'd5);
    checks++; if (mem_read !== 1'b1 || mem_addr !== 64'h10) begin fails++; $display("FAIL upd_read got %b/%h want 1/10", mem_read, mem_addr); end
    respond(64'd9);
    exp_d = {1'b1, 64'h10, 64'd5};
    checks++; if (valid_o !== 1'b1 || data_o !== exp_d) begin fails++; $display("FAIL upd_data got %b/%h want 1/%h", valid_o, data_o, exp_d); end
    accept;
    exp_cnt = 1;
    checks++; if (upd_cnt !== exp_cnt || ready_o !== 1'b1 || valid_o !== 1'b0) begin fails++; $display("FAIL upd_cnt got %0d/%b/%b want %0d/1/0", upd_cnt, ready_o, valid_o, exp_cnt); end
  endtask
  task automatic test_no_update;
    issue(64'h20, 64'd9);
    respond(64'd9);
`ifdef MIN_UPDATE_EN
    exp_d = {1'b0, 64'h20, 64'd9};
`else
    exp_d = {1'b1, 64'h20, 64'd9};
    exp_cnt = exp_cnt + 1;
`endif
    checks++; if (data_o !== exp_d) begin fails++; $display("FAIL equal_data got %h want %h", data_o, exp_d); end
    accept;
    checks++; if (upd_cnt !== exp_cnt) begin fails++; $display("FAIL equal_cnt got %0d want %0d", upd_cnt, exp_cnt); end
    issue(64'h30, 64'd12);
    respond(64'd9);
`ifdef MIN_UPDATE_EN
    exp_d = {1'b0, 64'h30, 64'd9};
`else
    exp_d = {1'b1, 64'h30, 64'd12};
    exp_cnt = exp_cnt + 1;
`endif
    checks++; if (data_o !== exp_d) begin fails++; $display("FAIL greater_data got %h want %h", data_o, exp_d); end
    accept;
    checks++; if (upd_cnt !== exp_cnt) begin fails++; $display("FAIL greater_cnt got %0d want %0d", upd_cnt, exp_cnt); end
  endtask
  task automatic test_backpressure;
    issue(64'h40, 64'd7);
    respond(64'd2);
`ifdef MIN_UPDATE_EN
    exp_d = {1'b0, 64'h40, 64'd2};
`else
    exp_d = {1'b1, 64'h40, 64'd7};
    exp_cnt = exp_cnt + 1;
`endif
    valid_i = 1;
    data_i = {64'hAA, 64'hBB};
    for (int i = 0; i < 5; i++) begin
      checks++; if (data_o !== exp_d || valid_o !== 1'b1 || ready_o !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got %h/%b/%b want %h/1/0", i, data_o, valid_o, ready_o, exp_d); end
      step;
    end
    accept;
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || mem_read !== 1'b0) begin fails++; $display("FAIL bp_release got %b/%b/%b want 1/0/0", ready_o, valid_o, mem_read); end
    valid_i = 0;
    checks++; if (upd_cnt !== exp_cnt) begin fails++; $display("FAIL bp_cnt got %0d want %0d", upd_cnt, exp_cnt); end
  endtask
  task automatic test_stall;
    issue(64'h50, 64'd1);
    for (int i = 0; i < 7; i++) begin
      mem_rdata = 64'hFFFF;
      checks++; if (mem_read !== 1'b1 || mem_addr !== 64'h50 || valid_o !== 1'b0) begin fails++; $display("FAIL stall%0d got %b/%h/%b want 1/50/0", i, mem_read, mem_addr, valid_o); end
      step;
    end
    mem_rdata = 64'd4;
    mem_resp = 1;
    checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL stall_early_valid got %b want 0", valid_o); end
    step;
    mem_resp = 0;
    exp_d = {1'b1, 64'h50, 64'd1};
    checks++; if (valid_o !== 1'b1 || data_o !== exp_d || mem_read !== 1'b0) begin fails++; $display("FAIL stall_out got %b/%h/%b want 1/%h/0", valid_o, data_o, mem_read, exp_d); end
    accept;
    exp_cnt = exp_cnt + 1;
    checks++; if (upd_cnt !== exp_cnt) begin fails++; $display("FAIL stall_cnt got %0d want %0d", upd_cnt, exp_cnt); end
  endtask
  task automatic test_reset_mid_read;
    issue(64'h60, 64'd3);
    step;
    rst = 1;
    step;
    rst = 0;
    exp_cnt = 0;
    checks++; if (ready_o !== 1'b1 || mem_read !== 1'b0 || valid_o !== 1'b0 || upd_cnt !== 32'd0 || data_o !== 129'd0) begin fails++; $display("FAIL midrst got %b/%b/%b/%0d/%h want 1/0/0/0/0", ready_o, mem_read, valid_o, upd_cnt, data_o); end
    respond(64'd1);
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 129'd0) begin fails++; $display("FAIL late_resp got %b/%b/%h want 0/1/0", valid_o, ready_o, data_o); end
  endtask
  task automatic test_overwrite;
    issue(64'h70, 64'd3);
    respond(64'd1);
`ifdef MIN_UPDATE_EN
    exp_d = {1'b0, 64'h70, 64'd1};
`else
    exp_d = {1'b1, 64'h70, 64'd3};
    exp_cnt = exp_cnt + 1;
`endif
    checks++; if (data_o !== exp_d) begin fails++; $display("FAIL overwrite_data got %h want %h", data_o, exp_d); end
    accept;
    checks++; if (upd_cnt !== exp_cnt) begin fails++; $display("FAIL overwrite_cnt got %0d want %0d", upd_cnt, exp_cnt); end
  endtask
  initial begin
    test_reset;
    test_update;
    test_no_update;
    test_backpressure;
    test_stall;
    test_reset_mid_read;
    test_overwrite;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
